gol_grid_ctrl: RTL and testbench

Owns the current 16x16 Game-of-Life generation register and feeds it to the downstream rule-evaluation stage as `grid`. It accepts that stage's registered `grid_next` and commits it either at a slow generation tick or on a manual single step. It also provides cell editing and clear while the game is stopped, and halts automatically when the pattern stops changing. It sits between the switch/key input logic and the update-logic stage; its `grid` output also drives the display path.

---
 rtl/gol_grid_ctrl.sv | 124 ++++++++++++
 tb/tb_gol_grid_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gol_grid_ctrl.sv
// gol_grid_ctrl: owns the current Game-of-Life generation register.
// Commits grid_next on generation ticks or single steps; edit/clear when stopped.
module gol_grid_ctrl #(
  parameter int TICK_DIV = 25_000_000,
  parameter int GEN_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_game,
  input  logic                    step,
  input  logic                    clear,
  input  logic                    edit_we,
  input  logic [3:0]              edit_row,
  input  logic [3:0]              edit_col,
  input  logic                    edit_val,
  input  logic [15:0][15:0]       grid_next,
  output logic [15:0][15:0]       grid,
  output logic [GEN_W-1:0]        gen_count,
  output logic [1:0]              state,
  output logic                    stable,
  output logic                    empty
);

  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_EDIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state_q;
  logic [15:0][15:0] grid_q;
  logic [GEN_W-1:0]  gen_q;
  logic              stable_q;
  logic [TW-1:0]     tick_q;
  logic              pend_q;
  logic [1:0]        settle_q;

  logic              ready;
  logic              term;
  logic              fire;
  logic              same;
  logic [GEN_W-1:0]  gen_inc;

  // grid_next only tracks grid once the settle window has drained
  assign ready   = (settle_q == 2'd0);
  assign term    = (tick_q == TW'(TICK_DIV - 1));
  assign fire    = (pend_q || term) && ready;
  assign same    = (grid_next == grid_q);
  assign gen_inc = (&gen_q) ? gen_q : gen_q + GEN_W'(1);

  // Single state machine owning grid, generation count and tick timing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_EDIT;
      grid_q   <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
      tick_q   <= '0;
      pend_q   <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      if (settle_q != 2'd0) settle_q <= settle_q - 2'd1;
      unique case (state_q)
        S_EDIT: begin
          if (clear) begin
            grid_q   <= '0;
            gen_q    <= '0;
            settle_q <= 2'd2;
          end else if (edit_we) begin
            grid_q[edit_row][edit_col] <= edit_val;
            settle_q <= 2'd2;
          end else if (step && ready) begin
            grid_q   <= grid_next;
            gen_q    <= gen_inc;
            settle_q <= 2'd2;
          end
          if (start_game) begin
            state_q <= S_RUN;
            tick_q  <= '0;
            pend_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!start_game) begin
            state_q <= S_EDIT;
            tick_q  <= '0;
            pend_q  <= 1'b0;
          end else begin
            tick_q <= term ? '0 : tick_q + TW'(1);
            if (fire) begin
              pend_q <= 1'b0;
              if (same) begin
                state_q  <= S_HALT;
                stable_q <= 1'b1;
              end else begin
                grid_q   <= grid_next;
                gen_q    <= gen_inc;
                settle_q <= 2'd2;
              end
            end else if (term) begin
              pend_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (!start_game) begin
            state_q  <= S_EDIT;
            stable_q <= 1'b0;
          end
        end
        default: state_q <= S_EDIT;
      endcase
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign state     = state_q;
  assign stable    = stable_q;
  assign empty     = (grid_q == '0);

endmodule

// File: tb/tb_gol_grid_ctrl.sv
// tb_gol_grid_ctrl: scoreboard bench for gol_grid_ctrl.
// Bench-side update stage registers Life(grid) into grid_next.
module tb_gol_grid_ctrl;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start_game;
  logic                    step;
  logic                    clear;
  logic                    edit_we;
  logic [3:0]              edit_row;
  logic [3:0]              edit_col;
  logic                    edit_val;
  logic [15:0][15:0]       grid_next;
  logic [15:0][15:0]       grid;
  logic [15:0]             gen_count;
  logic [1:0]              state;
  logic                    stable;
  logic                    empty;

  gol_grid_ctrl #(.TICK_DIV(4), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .start_game(start_game),
    .step(step), .clear(clear), .edit_we(edit_we),
    .edit_row(edit_row), .edit_col(edit_col), .edit_val(edit_val),
    .grid_next(grid_next), .grid(grid), .gen_count(gen_count),
    .state(state), .stable(stable), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0][15:0] life(input logic [15:0][15:0] g);
    logic [15:0][15:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 16 &&
                c + dc >= 0 && c + dc < 16)
              cnt += int'(g[r+dr][c+dc]);
        n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
      end
    end
    return n;
  endfunction

  always @(posedge clk) grid_next <= life(grid);

  typedef struct {
    string             tag;
    logic [15:0][15:0] g;
    logic [15:0]       gen;
    logic [1:0]        st;
    logic              stb;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  logic [275:0] snap, prev;

  task automatic push(input string t, input logic [15:0][15:0] g,
                      input int gen, input int st, input logic stb);
    exp_t x;
    x.tag = t; x.g = g; x.gen = 16'(gen); x.st = 2'(st); x.stb = stb;
    q.push_back(x);
  endtask

  // Monitor: every visible output change consumes one expectation
  always @(negedge clk) begin
    snap = {grid, gen_count, state, stable, empty};
    if (snap !== prev) begin
      prev = snap;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected: got grid=%h gen=%0d state=%0d stable=%0b",
                 grid, gen_count, state, stable);
      end else begin
        e = q.pop_front();
        if (grid !== e.g || gen_count !== e.gen || state !== e.st ||
            stable !== e.stb || empty !== (e.g == '0)) begin
          bad++;
          $display("FAIL %s: got grid=%h gen=%0d st=%0d stb=%0b emp=%0b want grid=%h gen=%0d st=%0d stb=%0b emp=%0b",
                   e.tag, grid, gen_count, state, stable, empty,
                   e.g, e.gen, e.st, e.stb, (e.g == '0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int r, input int c, input logic v);
    edit_row = 4'(r); edit_col = 4'(c); edit_val = v; edit_we = 1'b1;
    tick();
    edit_we = 1'b0;
  endtask

  task automatic stp();
    step = 1'b1;
    tick();
    step = 1'b0;
    ticks(2);
  endtask

  task automatic wait_gen(input int target, input int maxc);
    int k;
    k = 0;
    while (gen_count !== 16'(target) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (gen_count !== 16'(target)) begin
      total++;
      bad++;
      $display("FAIL wait_gen: got gen=%0d want %0d", gen_count, target);
    end
  endtask

  logic [15:0][15:0] m, h5, v5, h7, v7, blk;

  initial begin
    h5 = '0; h5[5][4] = 1; h5[5][5] = 1; h5[5][6] = 1;
    v5 = '0; v5[4][5] = 1; v5[5][5] = 1; v5[6][5] = 1;
    h7 = '0; h7[7][6] = 1; h7[7][7] = 1; h7[7][8] = 1;
    v7 = '0; v7[6][7] = 1; v7[7][7] = 1; v7[8][7] = 1;
    blk = '0; blk[0][0] = 1; blk[0][1] = 1; blk[1][0] = 1; blk[1][1] = 1;

    // reset wins over start_game and edit_we
    reset = 1; start_game = 1; step = 0; clear = 0;
    edit_we = 1; edit_row = 1; edit_col = 1; edit_val = 1;
    push("reset", '0, 0, 0, 0);
    ticks(2);
    reset = 0; edit_we = 0;
    push("run0", '0, 0, 1, 0);
    push("halt_empty", '0, 0, 2, 1);
    ticks(8);
    start_game = 0;
    push("edit0", '0, 0, 0, 0);
    ticks(3);

    // blinker runs without halting
    m = '0;
    m[5][4] = 1; push("wr54", m, 0, 0, 0); wr(5, 4, 1);
    m[5][5] = 1; push("wr55", m, 0, 0, 0); wr(5, 5, 1);
    m[5][6] = 1; push("wr56", m, 0, 0, 0); wr(5, 6, 1);
    push("run_blink", h5, 0, 1, 0);
    for (int k = 1; k <= 10; k++)
      push("blink_gen", (k % 2) ? v5 : h5, k, 1, 0);
    push("stop_term", h5, 10, 0, 0);
    start_game = 1;
    wait_gen(10, 200);
    // stop exactly on the next terminal-count edge
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1;
    start_game = 0;
    ticks(8);

    // clear, then step timing against settle window
    push("clear1", '0, 0, 0, 0);
    clear = 1; tick(); clear = 0;
    m = '0;
    m[7][6] = 1; push("wr76", m, 0, 0, 0); wr(7, 6, 1);
    m[7][7] = 1; push("wr77", m, 0, 0, 0); wr(7, 7, 1);
    m[7][8] = 1; push("wr78", m, 0, 0, 0); wr(7, 8, 1);
    step = 1; tick(); step = 0;
    tick();
    push("step1", v7, 1, 0, 0);
    stp();
    m = v7; m[0][0] = 1;
    push("step_and_wr", m, 1, 0, 0);
    edit_row = 0; edit_col = 0; edit_val = 1; edit_we = 1; step = 1;
    tick();
    edit_we = 0; step = 0;
    ticks(2);
    push("step2", h7, 2, 0, 0); stp();
    push("step3", v7, 3, 0, 0); stp();
    push("step4", h7, 4, 0, 0); stp();
    push("step5", v7, 5, 0, 0); stp();

    // clear beats edit_we in the same cycle
    push("clear_wr", '0, 0, 0, 0);
    edit_row = 3; edit_col = 3; edit_val = 1; edit_we = 1; clear = 1;
    tick();
    edit_we = 0; clear = 0;
    ticks(2);

    // still life halts at first tick
    m = '0;
    m[0][0] = 1; push("b00", m, 0, 0, 0); wr(0, 0, 1);
    m[0][1] = 1; push("b01", m, 0, 0, 0); wr(0, 1, 1);
    m[1][0] = 1; push("b10", m, 0, 0, 0); wr(1, 0, 1);
    m[1][1] = 1; push("b11", m, 0, 0, 0); wr(1, 1, 1);
    push("run_blk", blk, 0, 1, 0);
    push("halt_blk", blk, 0, 2, 1);
    start_game = 1;
    ticks(8);
    wr(5, 5, 1);
    clear = 1; tick(); clear = 0;
    step = 1; tick(); step = 0;
    ticks(3);
    push("unhalt", blk, 0, 0, 0);
    start_game = 0;
    ticks(5);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d pending want 0 (next %s)",
               q.size(), q[0].tag);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
